exec_iter: RTL and testbench
============================

EXEC_ITER -- requirements
Module: exec_iter

Interface
REQ-001 SHALL have parameter WORD, default 16, datapath width; power of two, >= 8.
REQ-002 SHALL have parameter W_RD, default 3, destination register number width.
REQ-003 SHALL have parameter W_STATUS, fixed at 4, status width, bit order {Z,N,C,V}.
REQ-004 SHALL have port clk  in  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port v_i  in  1  instruction valid from decode.
REQ-007 SHALL have port stall_o  out  1  unit cannot accept; decode holds its inputs.
REQ-008 SHALL have port opc_i  in  4  opcode.
REQ-009 SHALL have port src_i  in  WORD  operand B.
REQ-010 SHALL have port dest_i  in  WORD  operand A.
REQ-011 SHALL have port wb_i  in  1  instruction writes back.
REQ-012 SHALL have port rd_num_i  in  W_RD  destination register.
REQ-013 SHALL have port flush_i  in  1  synchronous kill of any in-flight operation.
REQ-014 SHALL have port v_o  out  1  result valid, one-cycle pulse.
REQ-015 SHALL have port wb_o  out  1  register-file write enable.
REQ-016 SHALL have port rd_num_o  out  W_RD  register-file write address.
REQ-017 SHALL have port rd_data_o  out  WORD  register-file write data.
REQ-018 SHALL have port status_o  out  W_STATUS  status register.

Function
REQ-019 SHALL accept an instruction in a cycle where v_i=1, stall_o=0 and flush_i=0.
REQ-020 SHALL decode opc_i: 0 ADD A+B, 1 SUB A-B, 2 AND, 3 OR, 4 XOR, 5 SHL, 6 SHR logical, 7 SAR, 8 MUL low WORD bits of A*B, 9 DIVU A/B, 10 REMU A%B, 11 PASS B; 12-15 NOP.
REQ-021 SHALL take shift amount from src_i[log2(WORD)-1:0]; the upper bits are ignored.
REQ-022 SHALL complete single-cycle ops (0-7, 11, NOP) with v_o=1 in the cycle after the accept edge, stall_o staying 0.
REQ-023 SHALL implement FSM states IDLE and BUSY; an accepted MUL/DIVU/REMU moves IDLE->BUSY and loads a step counter with WORD-1.
REQ-024 SHALL use shift-add for MUL and restoring division for DIVU/REMU, one bit per cycle in BUSY.
REQ-025 SHALL drive stall_o=1 exactly while in BUSY (Moore), i.e. WORD cycles after a multi-cycle accept.
REQ-026 SHALL, in BUSY with counter=0, register the result, pulse v_o and return to IDLE at that edge; the result appears WORD cycles after accept.
REQ-027 SHALL permit a new accept in the same cycle v_o pulses for the previous op (back-to-back, no bubble).
REQ-028 SHALL drive wb_o = wb_i captured at accept AND opcode not NOP, only during the v_o pulse; otherwise wb_o=0.
REQ-029 SHALL hold rd_num_o/rd_data_o stable between pulses.
REQ-030 SHALL compute flags: Z=result==0, N=result[WORD-1] for every op.
REQ-031 SHALL compute C as ADD carry-out, SUB borrow (A<B unsigned), SHL/SHR/SAR last bit shifted out (0 when amount=0), MUL high half nonzero, and 0 otherwise.
REQ-032 SHALL compute V as signed overflow for ADD/SUB, divide-by-zero for DIVU/REMU, and 0 otherwise.
REQ-033 SHALL, on B=0, return all-ones for DIVU, return A for REMU, and set V=1, with full WORD-cycle latency.
REQ-034 SHALL update status_o on each v_o pulse except NOP, and hold it otherwise.
REQ-035 SHALL, on flush_i=1, return to IDLE at the next edge, suppress the pending v_o/wb_o, block acceptance in that cycle and leave status_o unchanged.
REQ-036 SHALL give flush_i priority over completion when both occur in the same cycle.

Reset
REQ-037 SHALL, on rst=0, immediately force FSM=IDLE, counter=0 and v_o=wb_o=0, with rd_num_o=0, rd_data_o=0 and status_o=0 (stall_o=0 follows).
REQ-038 SHALL discard an in-flight multi-cycle op on reset mid-operation, producing no v_o after release.

Verification
REQ-039 SHALL pass: WORD=16, ADD A=0x7FFF B=0x0001 -> next cycle v_o=1, rd_data_o=0x8000, status {Z,N,C,V}=0101.
REQ-040 SHALL pass: DIVU A=100 B=7 rd_num=5 wb=1 -> stall_o=1 for 16 cycles; then v_o=1, wb_o=1, rd_num_o=5, rd_data_o=14, status=0000; REMU gives 2.
REQ-041 SHALL pass: DIVU A=0x1234 B=0 -> after 16 cycles rd_data_o=0xFFFF, status=0101; REMU gives 0x1234, V=1.
REQ-042 SHALL pass: MUL 0x0100*0x0100 -> rd_data_o=0x0000, Z=1, C=1; with SUB A=3 B=5 offered during BUSY, SUB accepted only in the MUL's v_o cycle, result 0xFFFE, N=1, C=1 one cycle later.
REQ-043 SHALL pass: flush_i at cycle 8 of MUL -> no v_o, stall_o=0 next cycle, status_o unchanged; likewise rst low at cycle 5 of DIVU -> all outputs 0, no later v_o.
REQ-044 SHALL pass: SAR 0x8001 by src=0x0011 (amount 1) -> 0xC000, C=1, N=1; NOP with wb_i=1 -> v_o=1, wb_o=0, status unchanged.

Source files
------------

// File: rtl/exec_iter.sv
// Execution unit: ALU ops in one cycle, MUL/DIVU/REMU iterate one bit per cycle.
// Latency: 1 cycle for single-cycle ops and NOP, WORD cycles for MUL/DIVU/REMU.
// Backpressure: stall_o is high for the whole BUSY period; flush_i kills in-flight work.
module exec_iter #(
    parameter int WORD     = 16,
    parameter int W_RD     = 3,
    parameter int W_STATUS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                v_i,
    output logic                stall_o,
    input  logic [3:0]          opc_i,
    input  logic [WORD-1:0]     src_i,
    input  logic [WORD-1:0]     dest_i,
    input  logic                wb_i,
    input  logic [W_RD-1:0]     rd_num_i,
    input  logic                flush_i,
    output logic                v_o,
    output logic                wb_o,
    output logic [W_RD-1:0]     rd_num_o,
    output logic [WORD-1:0]     rd_data_o,
    output logic [W_STATUS-1:0] status_o
);

    localparam int SH_W = $clog2(WORD);

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_SHL  = 4'd5;
    localparam logic [3:0] OP_SHR  = 4'd6;
    localparam logic [3:0] OP_SAR  = 4'd7;
    localparam logic [3:0] OP_MUL  = 4'd8;
    localparam logic [3:0] OP_DIVU = 4'd9;
    localparam logic [3:0] OP_REMU = 4'd10;
    localparam logic [3:0] OP_PASS = 4'd11;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t            state_q, state_d;
    logic              accept;
    logic              done;
    logic              in_multi;
    logic              in_nop;

    logic [SH_W-1:0]   cnt_q;
    logic [3:0]        opc_q;
    logic              wb_q;
    logic [W_RD-1:0]   rd_q;
    // MUL: acc_hi = partial product high half, acc_lo = multiplier shifting out, opnd = multiplicand.
    // DIV: acc_hi = partial remainder, acc_lo = dividend shifting out / quotient shifting in, opnd = divisor.
    logic [WORD-1:0]   acc_hi_q, acc_lo_q, opnd_q;
    logic [WORD-1:0]   hi_nxt, lo_nxt;
    logic [WORD:0]     mul_sum, div_shift, div_diff;
    logic              div_ge;

    logic [WORD-1:0]   m_res;
    logic              m_c, m_v;

    logic [SH_W-1:0]   sh;
    logic [WORD:0]     sum_w, diff_w, shl_w, shr_w, sar_w;
    logic [WORD-1:0]   alu_res;
    logic              alu_c, alu_v;

    assign in_multi = (opc_i == OP_MUL) || (opc_i == OP_DIVU) || (opc_i == OP_REMU);
    assign in_nop   = (opc_i[3:2] == 2'b11);
    assign sh       = src_i[SH_W-1:0];

    // Next-state logic; flush wins over completion, and blocks acceptance.
    always_comb begin
        state_d = state_q;
        done    = 1'b0;
        stall_o = (state_q == BUSY);
        accept  = v_i && (state_q == IDLE) && !flush_i;
        case (state_q)
            IDLE: begin
                if (accept && in_multi) state_d = BUSY;
            end
            BUSY: begin
                if (flush_i) begin
                    state_d = IDLE;
                end else if (cnt_q == '0) begin
                    state_d = IDLE;
                    done    = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // One iteration step: shift-add for MUL, restoring subtract for DIVU/REMU.
    // With a zero divisor every compare succeeds, so the quotient fills with ones
    // and the dividend bits pass straight into the remainder, giving A.
    always_comb begin
        mul_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : {(WORD+1){1'b0}});
        div_shift = {acc_hi_q, acc_lo_q[WORD-1]};
        div_diff  = div_shift - {1'b0, opnd_q};
        div_ge    = (div_shift >= {1'b0, opnd_q});
        if (opc_q == OP_MUL) begin
            {hi_nxt, lo_nxt} = {mul_sum, acc_lo_q[WORD-1:1]};
        end else begin
            hi_nxt = div_ge ? div_diff[WORD-1:0] : div_shift[WORD-1:0];
            lo_nxt = {acc_lo_q[WORD-2:0], div_ge};
        end
        m_res = (opc_q == OP_REMU) ? hi_nxt : lo_nxt;
        m_c   = (opc_q == OP_MUL) && (hi_nxt != '0);
        m_v   = (opc_q != OP_MUL) && (opnd_q == '0);
    end

    // Iterative datapath: load on multi-cycle accept, step every BUSY cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q    <= '0;
            opc_q    <= '0;
            wb_q     <= 1'b0;
            rd_q     <= '0;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            opnd_q   <= '0;
        end else if (accept && in_multi) begin
            cnt_q    <= SH_W'(WORD - 1);
            opc_q    <= opc_i;
            wb_q     <= wb_i;
            rd_q     <= rd_num_i;
            acc_hi_q <= '0;
            acc_lo_q <= (opc_i == OP_MUL) ? src_i : dest_i;
            opnd_q   <= (opc_i == OP_MUL) ? dest_i : src_i;
        end else if (state_q == BUSY) begin
            acc_hi_q <= hi_nxt;
            acc_lo_q <= lo_nxt;
            if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
        end
    end

    // Single-cycle ALU; shifts run one bit wide so the bit shifted out lands in the spare bit.
    always_comb begin
        sum_w   = {1'b0, dest_i} + {1'b0, src_i};
        diff_w  = {1'b0, dest_i} - {1'b0, src_i};
        shl_w   = {1'b0, dest_i} << sh;
        shr_w   = {dest_i, 1'b0} >> sh;
        sar_w   = $signed({dest_i, 1'b0}) >>> sh;
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (opc_i)
            OP_ADD: begin
                alu_res = sum_w[WORD-1:0];
                alu_c   = sum_w[WORD];
                alu_v   = (dest_i[WORD-1] == src_i[WORD-1]) && (alu_res[WORD-1] != dest_i[WORD-1]);
            end
            OP_SUB: begin
                alu_res = diff_w[WORD-1:0];
                alu_c   = diff_w[WORD];
                alu_v   = (dest_i[WORD-1] != src_i[WORD-1]) && (alu_res[WORD-1] != dest_i[WORD-1]);
            end
            OP_AND:  alu_res = dest_i & src_i;
            OP_OR:   alu_res = dest_i | src_i;
            OP_XOR:  alu_res = dest_i ^ src_i;
            OP_SHL:  {alu_c, alu_res} = shl_w;
            OP_SHR:  {alu_res, alu_c} = shr_w;
            OP_SAR:  {alu_res, alu_c} = sar_w;
            OP_PASS: alu_res = src_i;
            default: alu_res = '0;
        endcase
    end

    // Result registers: pulse v_o/wb_o, hold data and status between pulses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v_o       <= 1'b0;
            wb_o      <= 1'b0;
            rd_num_o  <= '0;
            rd_data_o <= '0;
            status_o  <= '0;
        end else begin
            v_o  <= 1'b0;
            wb_o <= 1'b0;
            if (accept && !in_multi) begin
                v_o <= 1'b1;
                if (!in_nop) begin
                    wb_o      <= wb_i;
                    rd_num_o  <= rd_num_i;
                    rd_data_o <= alu_res;
                    status_o  <= {(alu_res == '0), alu_res[WORD-1], alu_c, alu_v};
                end
            end else if (done) begin
                v_o       <= 1'b1;
                wb_o      <= wb_q;
                rd_num_o  <= rd_q;
                rd_data_o <= m_res;
                status_o  <= {(m_res == '0), m_res[WORD-1], m_c, m_v};
            end
        end
    end

endmodule

// File: tb/tb_exec_iter.sv
module tb_exec_iter;

    localparam int WORD = 16;
    localparam int W_RD = 3;

    logic            clk = 1'b0;
    logic            rst;
    logic            v_i;
    logic            stall_o;
    logic [3:0]      opc_i;
    logic [15:0]     src_i;
    logic [15:0]     dest_i;
    logic            wb_i;
    logic [2:0]      rd_num_i;
    logic            flush_i;
    logic            v_o;
    logic            wb_o;
    logic [2:0]      rd_num_o;
    logic [15:0]     rd_data_o;
    logic [3:0]      status_o;

    always #5 clk = ~clk;

    exec_iter #(.WORD(WORD), .W_RD(W_RD), .W_STATUS(4)) dut (
        .clk(clk), .rst(rst), .v_i(v_i), .stall_o(stall_o), .opc_i(opc_i),
        .src_i(src_i), .dest_i(dest_i), .wb_i(wb_i), .rd_num_i(rd_num_i),
        .flush_i(flush_i), .v_o(v_o), .wb_o(wb_o), .rd_num_o(rd_num_o),
        .rd_data_o(rd_data_o), .status_o(status_o)
    );

    typedef struct {
        logic        wb;
        logic [2:0]  rd;
        logic [15:0] data;
        logic [3:0]  st;
    } exp_t;

    exp_t        sbq[$];
    int          checks   = 0;
    int          failures = 0;
    int          prev_multi = 0;

    // Architectural state as the reference model sees it (in program order).
    logic [2:0]  m_rd   = '0;
    logic [15:0] m_data = '0;
    logic [3:0]  m_st   = '0;

    // Values the outputs must hold between pulses.
    logic [2:0]  h_rd   = '0;
    logic [15:0] h_data = '0;
    logic [3:0]  h_st   = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference model: plain arithmetic on the architectural definition of each opcode.
    function automatic exp_t model(input int op, input logic [15:0] a, input logic [15:0] b,
                                   input logic wb, input logic [2:0] rd);
        exp_t        e;
        logic [63:0] res;
        int          n, c, v, sa, sb, s;
        n  = int'(b) % 16;
        sa = $signed(a);
        sb = $signed(b);
        c = 0; v = 0; res = '0;
        e.wb = wb; e.rd = rd;
        case (op)
            0: begin res = 64'(a) + 64'(b); c = int'(res[16]); s = sa + sb; v = (s > 32767 || s < -32768) ? 1 : 0; end
            1: begin res = 64'(a) - 64'(b); c = (a < b) ? 1 : 0; s = sa - sb; v = (s > 32767 || s < -32768) ? 1 : 0; end
            2: res = 64'(a & b);
            3: res = 64'(a | b);
            4: res = 64'(a ^ b);
            5: begin res = 64'(a) << n; c = (n == 0) ? 0 : int'(res[16]); end
            6: begin res = 64'(a) >> n; c = (n == 0) ? 0 : (int'(a) >> (n - 1)) & 1; end
            7: begin res = 64'(sa >>> n); c = (n == 0) ? 0 : (int'(a) >> (n - 1)) & 1; end
            8: begin res = 64'(a) * 64'(b); c = (res[31:16] != 0) ? 1 : 0; end
            9: begin if (b == 0) begin res = 64'hFFFF; v = 1; end else res = 64'(a) / 64'(b); end
            10: begin if (b == 0) begin res = 64'(a); v = 1; end else res = 64'(a) % 64'(b); end
            11: res = 64'(b);
            default: begin
                e.wb = 1'b0; e.rd = m_rd; e.data = m_data; e.st = m_st;
                return e;
            end
        endcase
        e.data = res[15:0];
        e.st   = {(e.data == 16'h0), e.data[15], c[0], v[0]};
        return e;
    endfunction

    // Scoreboard monitor: pop and compare on each v_o, otherwise check idle/hold behaviour.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            chk("rst_v_o", v_o, 0);
            chk("rst_wb_o", wb_o, 0);
            chk("rst_rd_data", rd_data_o, 0);
            chk("rst_status", status_o, 0);
            h_rd = '0; h_data = '0; h_st = '0;
        end else if (v_o) begin
            checks++;
            if (sbq.size() == 0) begin
                failures++;
                $display("FAIL unexpected_v_o actual=1 required=0 data=%0h", rd_data_o);
            end else begin
                e = sbq.pop_front();
                chk("wb_o", wb_o, e.wb);
                chk("rd_num_o", rd_num_o, e.rd);
                chk("rd_data_o", rd_data_o, e.data);
                chk("status_o", status_o, e.st);
                h_rd = e.rd; h_data = e.data; h_st = e.st;
            end
        end else begin
            chk("wb_idle", wb_o, 0);
            chk("hold_rd", rd_num_o, h_rd);
            chk("hold_data", rd_data_o, h_data);
            chk("hold_status", status_o, h_st);
        end
    end

    task automatic wait_ready(output int n);
        n = 0;
        while (stall_o === 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk("stall_timeout", n, 0);
    endtask

    task automatic issue(input int op, input logic [15:0] a, input logic [15:0] b,
                         input logic wb, input logic [2:0] rd);
        int   n;
        exp_t e;
        @(negedge clk);
        v_i = 1'b1; opc_i = op[3:0]; dest_i = a; src_i = b; wb_i = wb; rd_num_i = rd;
        wait_ready(n);
        chk("stall_cycles", n, (prev_multi != 0) ? 16 : 0);
        e = model(op, a, b, wb, rd);
        sbq.push_back(e);
        if (op < 12) begin m_rd = e.rd; m_data = e.data; m_st = e.st; end
        prev_multi = (op >= 8 && op <= 10) ? 1 : 0;
        @(posedge clk);
    endtask

    task automatic idle(input int cycles);
        int n;
        @(negedge clk);
        v_i = 1'b0;
        wait_ready(n);
        chk("stall_cycles_idle", n, (prev_multi != 0) ? 16 : 0);
        prev_multi = 0;
        repeat (cycles - 1) @(negedge clk);
    endtask

    function automatic logic [15:0] rnd16();
        case ($urandom_range(0, 5))
            0: return 16'h0000;
            1: return 16'hFFFF;
            2: return 16'h8000;
            3: return 16'h7FFF;
            4: return 16'($urandom_range(0, 17));
            default: return 16'($urandom);
        endcase
    endfunction

    initial begin
        #5_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; v_i = 1'b0; opc_i = '0; src_i = '0; dest_i = '0;
        wb_i = 1'b0; rd_num_i = '0; flush_i = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_stall", stall_o, 0);
        #2 rst = 1'b1;

        // Directed cases from the feature list.
        issue(0, 16'h7FFF, 16'h0001, 1'b1, 3'd1);
        issue(9, 16'd100, 16'd7, 1'b1, 3'd5);
        issue(10, 16'd100, 16'd7, 1'b1, 3'd5);
        issue(9, 16'h1234, 16'h0000, 1'b1, 3'd2);
        issue(10, 16'h1234, 16'h0000, 1'b1, 3'd3);
        issue(8, 16'h0100, 16'h0100, 1'b1, 3'd4);
        issue(1, 16'd3, 16'd5, 1'b1, 3'd6);
        issue(7, 16'h8001, 16'h0011, 1'b1, 3'd7);
        issue(12, 16'h5555, 16'h0001, 1'b1, 3'd1);
        idle(3);

        // Randomized traffic with occasional bubbles.
        for (int i = 0; i < 250; i++) begin
            issue(int'($urandom_range(0, 15)), rnd16(), rnd16(), 1'($urandom), 3'($urandom));
            if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
        end
        idle(3);

        // Flush in BUSY cycle 8 of a MUL: no result, stall drops, status held.
        @(negedge clk);
        v_i = 1'b1; opc_i = 4'd8; dest_i = 16'h00FF; src_i = 16'h0003; wb_i = 1'b1; rd_num_i = 3'd2;
        @(posedge clk);
        @(negedge clk);
        v_i = 1'b0;
        repeat (7) @(negedge clk);
        chk("stall_in_busy", stall_o, 1);
        flush_i = 1'b1;
        @(negedge clk);
        flush_i = 1'b0;
        chk("stall_after_flush", stall_o, 0);
        idle(20);

        // Flush in IDLE blocks an offered instruction.
        @(negedge clk);
        v_i = 1'b1; opc_i = 4'd0; dest_i = 16'h0001; src_i = 16'h0001; flush_i = 1'b1;
        @(negedge clk);
        v_i = 1'b0; flush_i = 1'b0;
        idle(4);

        // Reset in BUSY cycle 5 of a DIVU: outputs clear, nothing comes out later.
        @(negedge clk);
        v_i = 1'b1; opc_i = 4'd9; dest_i = 16'd100; src_i = 16'd7; wb_i = 1'b1; rd_num_i = 3'd5;
        @(posedge clk);
        @(negedge clk);
        v_i = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("arst_v_o", v_o, 0);
        chk("arst_wb_o", wb_o, 0);
        chk("arst_rd_num", rd_num_o, 0);
        chk("arst_rd_data", rd_data_o, 0);
        chk("arst_status", status_o, 0);
        chk("arst_stall", stall_o, 0);
        m_rd = '0; m_data = '0; m_st = '0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        prev_multi = 0;
        idle(25);

        // A short burst after reset to confirm normal operation resumes.
        issue(2, 16'hF0F0, 16'h3C3C, 1'b1, 3'd3);
        issue(5, 16'h8001, 16'h0001, 1'b0, 3'd4);
        issue(10, 16'd1000, 16'd33, 1'b1, 3'd6);
        idle(3);

        chk("scoreboard_empty", sbq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
